addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake and condition-code outputs. It is the successor to the flat 64-bit combinational add/sub in the ALU: the carry chain is split into `STAGES` registered slices, and it produces ZF/SF/OF/CF for the condition-code register. It sits between the execute-stage operand muxes and the CC/valE writeback path. It accepts one operation per cycle and stalls under downstream backpressure.

---
 rtl/addsub_pipe_if.sv | 27 ++
 rtl/addsub_pipe.sv | 107 ++++++++++
 tb/tb_addsub_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// rtl/addsub_pipe_if.sv - operand/result handshake bundle for addsub_pipe
interface addsub_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cf;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, zf, sf, of, cf
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, zf, sf, of, cf
  );
endinterface

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined add/sub, carry chain split into STAGES registered slices
module addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam int SK    = (STAGES > 1) ? STAGES - 1 : 1;

  // Inter-stage registers: skewed operands, partial result, carry, valid
  logic [WIDTH-1:0] r_a [SK];
  logic [WIDTH-1:0] r_b [SK];
  logic [WIDTH-1:0] r_s [SK];
  logic             r_c [SK];
  logic             r_v [SK];

  logic [WIDTH-1:0] r_out;
  logic             r_ov;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic             r_cf;

  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_out [STAGES];
  logic [CHUNK-1:0] w_chunk [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_c_out [STAGES];
  logic             w_v_in  [STAGES];
  logic             w_adv;

  assign w_adv = !r_ov || bus.out_ready;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_in[k] = bus.in1;
      assign w_b_in[k] = bus.in2 ^ {WIDTH{bus.op}};
      assign w_s_in[k] = '0;
      assign w_c_in[k] = bus.op;
      assign w_v_in[k] = bus.in_valid;
    end else begin : g_next
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_v_in[k] = r_v[k-1];
    end

    assign {w_c_out[k], w_chunk[k]} = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                                    + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                                    + (CHUNK+1)'(w_c_in[k]);
    // Slices above k are still zero here, so OR-ing in this slice is enough
    assign w_s_out[k] = w_s_in[k] | (WIDTH'(w_chunk[k]) << (k * CHUNK));

    if (k < LAST) begin : g_mid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a[k] <= '0;
          r_b[k] <= '0;
          r_s[k] <= '0;
          r_c[k] <= 1'b0;
          r_v[k] <= 1'b0;
        end else if (w_adv) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_out[k];
          r_c[k] <= w_c_out[k];
          r_v[k] <= w_v_in[k];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ov  <= 1'b0;
          r_out <= '0;
          r_zf  <= 1'b0;
          r_sf  <= 1'b0;
          r_of  <= 1'b0;
          r_cf  <= 1'b0;
        end else if (w_adv) begin
          r_ov  <= w_v_in[k];
          r_out <= w_s_out[k];
          r_zf  <= (w_s_out[k] == '0);
          r_sf  <= w_s_out[k][WIDTH-1];
          r_of  <= (w_a_in[k][WIDTH-1] == w_b_in[k][WIDTH-1])
                && (w_s_out[k][WIDTH-1] != w_a_in[k][WIDTH-1]);
          r_cf  <= w_c_out[k];
        end
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_ov;
  assign bus.out       = r_out;
  assign bus.zf        = r_zf;
  assign bus.sf        = r_sf;
  assign bus.of        = r_of;
  assign bus.cf        = r_cf;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed bench for addsub_pipe at 64/4, 16/1 and 16/16
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          sel     = 0;
  int          rs_seen = 0;
  logic        t_valid = 1'b0;
  logic        t_op    = 1'b0;
  logic        t_ready = 1'b1;
  logic [63:0] t_in1   = '0;
  logic [63:0] t_in2   = '0;

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(64)) if_a ();
  addsub_pipe_if #(.WIDTH(16)) if_b ();
  addsub_pipe_if #(.WIDTH(16)) if_c ();

  assign if_a.in_valid  = t_valid && (sel == 0);
  assign if_a.in1       = t_in1;
  assign if_a.in2       = t_in2;
  assign if_a.op        = t_op;
  assign if_a.out_ready = t_ready;
  assign if_b.in_valid  = t_valid && (sel == 1);
  assign if_b.in1       = t_in1[15:0];
  assign if_b.in2       = t_in2[15:0];
  assign if_b.op        = t_op;
  assign if_b.out_ready = t_ready;
  assign if_c.in_valid  = t_valid && (sel == 2);
  assign if_c.in1       = t_in1[15:0];
  assign if_c.in2       = t_in2[15:0];
  assign if_c.op        = t_op;
  assign if_c.out_ready = t_ready;

  addsub_pipe #(.WIDTH(64), .STAGES(4))  u_a (.clk(clk), .rst(rst), .bus(if_a));
  addsub_pipe #(.WIDTH(16), .STAGES(1))  u_b (.clk(clk), .rst(rst), .bus(if_b));
  addsub_pipe #(.WIDTH(16), .STAGES(16)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  logic        o_valid;
  logic        o_in_ready;
  logic [63:0] o_out;
  logic [3:0]  o_flags;

  always_comb begin
    o_valid    = if_a.out_valid;
    o_in_ready = if_a.in_ready;
    o_out      = if_a.out;
    o_flags    = {if_a.zf, if_a.sf, if_a.of, if_a.cf};
    case (sel)
      1: begin
        o_valid    = if_b.out_valid;
        o_in_ready = if_b.in_ready;
        o_out      = {48'h0, if_b.out};
        o_flags    = {if_b.zf, if_b.sf, if_b.of, if_b.cf};
      end
      2: begin
        o_valid    = if_c.out_valid;
        o_in_ready = if_c.in_ready;
        o_out      = {48'h0, if_c.out};
        o_flags    = {if_c.zf, if_c.sf, if_c.of, if_c.cf};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated op: checks acceptance, latency, result, flags {zf,sf,of,cf}, one-cycle valid
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic op, input logic [63:0] exp_out,
                        input logic [3:0] exp_f, input int lat);
    int seen = 0;
    @(negedge clk);
    t_ready = 1'b1; t_in1 = a; t_in2 = b; t_op = op; t_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, 64'(o_in_ready), 64'd1);
    @(negedge clk);
    t_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (o_valid) begin
        seen = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(seen), 64'(lat));
    check({tag, " out"}, o_out, exp_out);
    check({tag, " flags"}, 64'(o_flags), 64'(exp_f));
    @(negedge clk);
    check({tag, " valid drop"}, 64'(o_valid), 64'd0);
  endtask

  // Eight ops i+i; out_ready held low for 3 cycles after the second result is taken
  task automatic stream_test(input string tag);
    int          nsent = 0;
    int          nrecv = 0;
    int          stall_left = 0;
    logic [63:0] held = '0;
    for (int cyc = 0; cyc < 200 && nrecv < 8; cyc++) begin
      @(negedge clk);
      t_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        check({tag, " stall in_ready"}, 64'(o_in_ready), 64'd0);
        if (stall_left == 3) held = o_out;
        else check({tag, " stall hold"}, o_out, held);
        stall_left--;
      end else begin
        check({tag, " run in_ready"}, 64'(o_in_ready), 64'd1);
      end
      if (o_valid && t_ready) begin
        check({tag, " result"}, o_out, 64'(2 * (nrecv + 1)));
        nrecv++;
        if (nrecv == 2) stall_left = 3;
      end
      if (nsent < 8) begin
        t_valid = 1'b1; t_op = 1'b0;
        t_in1 = 64'(nsent + 1); t_in2 = 64'(nsent + 1);
        if (o_in_ready) nsent++;
      end else begin
        t_valid = 1'b0;
      end
    end
    check({tag, " received"}, 64'(nrecv), 64'd8);
    t_valid = 1'b0; t_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, " no extra"}, 64'(o_valid), 64'd0);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset valid", 64'(o_valid), 64'd0);
      check("reset out", o_out, 64'd0);
      check("reset flags", 64'(o_flags), 64'd0);
      check("reset in_ready", 64'(o_in_ready), 64'd1);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;

    run_op("w64 5+3", 64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 4);
    run_op("w64 max+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b0110, 4);
    run_op("w64 ones+1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b1001, 4);
    run_op("w64 5-5", 64'd5, 64'd5, 1'b1, 64'd0, 4'b1001, 4);
    run_op("w64 0-1", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 4);
    run_op("w64 min-1", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 4);
    stream_test("w64 stream");

    // Reset with three ops in flight
    @(negedge clk);
    t_ready = 1'b1; t_op = 1'b0; t_in2 = 64'd1; t_in1 = 64'd10; t_valid = 1'b1;
    @(negedge clk);
    t_in1 = 64'd20;
    @(negedge clk);
    t_in1 = 64'd30;
    @(negedge clk);
    t_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst out", o_out, 64'd0);
    check("rst flags", 64'(o_flags), 64'd0);
    check("rst in_ready", 64'(o_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_valid) rs_seen++;
    end
    check("rst discarded", 64'(rs_seen), 64'd0);
    run_op("w64 after rst", 64'd7, 64'd8, 1'b0, 64'd15, 4'b0000, 4);

    sel = 1;
    run_op("w16s1 max+1", 64'h7FFF, 64'd1, 1'b0, 64'h8000, 4'b0110, 1);
    run_op("w16s1 0-1", 64'd0, 64'd1, 1'b1, 64'hFFFF, 4'b0100, 1);
    stream_test("w16s1 stream");

    sel = 2;
    run_op("w16s16 max+1", 64'h7FFF, 64'd1, 1'b0, 64'h8000, 4'b0110, 16);
    run_op("w16s16 ones+1", 64'hFFFF, 64'd1, 1'b0, 64'd0, 4'b1001, 16);
    stream_test("w16s16 stream");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
